dual_slope_pwm: RTL and testbench
=================================

// Module: dual_slope_pwm
// PURPOSE
//   Free-running, center-aligned (dual-slope, up/down counter) PWM generator.
//   A RESOLUTION-bit counter ramps 0 -> MAX -> 0 continuously.
//   PWM_out is high while the counter is below the fixed DUTY threshold.
//   Standalone timing source for motor/LED drive stages; needs only clk and rst.
// PARAMETERS
//   RESOLUTION  10   counter width in bits; MAX = 2**RESOLUTION-1 (1023 at default)
//   DUTY        256  compare threshold, legal range 0..2**RESOLUTION; must fit RESOLUTION+1 bits
// PORTS
//   clk        in   1           rising-edge clock, sole clock domain
//   rst        in   1           asynchronous, active-high reset
//   PWM_out    out  1           center-aligned PWM output, registered
//   counter    out  RESOLUTION  debug: current ramp value; may be left unconnected
//   direction  out  1           debug: 1 = counting up, 0 = counting down; may be left unconnected
// BEHAVIOUR
//   - Reset (async assert, release synchronous to clk): counter=0, direction=1, PWM_out=0.
//     Mid-operation reset behaves identically: immediate clear, no partial period completed.
//   - Counter sequence, one step per clk:
//     0,1,...,MAX-1,MAX,MAX-1,...,1,0,1,...
//   - Period = 2*MAX clocks (2046 at default; 20.46 us at 100 MHz).
//   - Counter dwells exactly one cycle at MAX and one cycle at 0; no double peak or valley.
//   - Direction register:
//     - Cleared on the clock that loads MAX (next step counts down).
//     - Set on the clock that loads 0 (next step counts up).
//     - direction output always matches the step that follows the current counter value.
//   - Counter never exceeds MAX and never underflows below 0; no wrap-around path exists.
//   - PWM_out is registered from next-counter:
//     - PWM_out <= (counter_next < DUTY), so PWM_out is aligned with the counter value it reflects.
//     - Unsigned compare at RESOLUTION+1 bits.
//   - High time per period = 2*DUTY-1 clocks for 1 <= DUTY <= MAX. High pulse is symmetric about the valley (counter=0).
//   - Boundary cases:
//     - DUTY=0: PWM_out constantly 0.
//     - DUTY=MAX: PWM_out low for exactly one cycle per period, at the peak.
//     - DUTY=2**RESOLUTION: PWM_out constantly 1 after the first clock out of reset.
//   - First clock after reset release: counter=1, PWM_out=(1<DUTY).
//   - No other inputs; output depends only on the number of clocks since reset.
// TESTING
//   - Reset: clk 10 ns; hold rst=1 for 10 ns at t=110 ns.
//     -> counter=0, direction=1, PWM_out=0 during reset.
//     -> counter=1 on first edge after release.
//   - Ramp: from reset, count 1023 clocks.
//     -> counter=1023, direction=0.
//     -> next edge counter=1022; after 2046 clocks total, counter=0, direction=1.
//   - Duty: default DUTY=256; measure steady-state PWM_out over 500 us.
//     -> high 511 clocks, low 1535 clocks, period 2046 clocks, every period identical.
//   - Boundaries: rebuild with DUTY=0, DUTY=1023, DUTY=1024.
//     -> DUTY=0: always low.
//     -> DUTY=1023: one low cycle per period, at counter=1023.
//     -> DUTY=1024: always high.
//   - Mid-run reset: assert rst while counting down at counter=600.
//     -> outputs clear immediately, without waiting for clk.
//     -> ramp restarts from 0 upward after release.
//   - Width: rebuild with RESOLUTION=4, DUTY=4.
//     -> period 30 clocks, high 7 clocks, peak counter=15.

Source files
------------

// File: rtl/dual_slope_pwm_if.sv
// Output bundle of the center-aligned PWM generator: the PWM waveform plus
// the debug view of the ramp (current counter value and slope direction).
interface dual_slope_pwm_if #(
    parameter int unsigned RESOLUTION = 10
);
    logic                  PWM_out;
    logic [RESOLUTION-1:0] counter;
    logic                  direction;

    // Generator side drives everything.
    modport master (
        output PWM_out,
        output counter,
        output direction
    );

    // Consumer side (drive stage, debug monitor) only observes.
    modport slave (
        input PWM_out,
        input counter,
        input direction
    );
endinterface

// File: rtl/dual_slope_pwm.sv
// Free-running, center-aligned (dual-slope) PWM generator.
// A RESOLUTION-bit counter ramps 0 -> MAX -> 0; PWM_out is high while the
// counter is below DUTY. Period is 2*MAX clocks with a single-cycle dwell
// at both the peak and the valley.
module dual_slope_pwm #(
    parameter int unsigned RESOLUTION = 10,
    parameter int unsigned DUTY       = 256
) (
    input  logic             clk,
    input  logic             rst,
    dual_slope_pwm_if.master pwm_bus
);
    localparam logic [RESOLUTION-1:0] CNT_MAX  = '1;
    localparam logic [RESOLUTION-1:0] CNT_ZERO = '0;
    localparam logic [RESOLUTION-1:0] CNT_ONE  = RESOLUTION'(1);
    // Threshold is one bit wider than the counter so DUTY = 2**RESOLUTION
    // (always high) is representable.
    localparam logic [RESOLUTION:0]   DUTY_CMP = (RESOLUTION + 1)'(DUTY);

    // Slope state: the direction of the step that follows the current value.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    dir_e                  dir_q, dir_d;
    logic [RESOLUTION-1:0] cnt_q, cnt_d;
    logic                  pwm_q, pwm_d;

    // Next-state: step the ramp, flip direction on the extremes, and compare
    // the value being loaded so PWM_out lines up with the counter it reflects.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        cnt_d = cnt_q;
        dir_d = dir_q;
        pwm_d = 1'b0;

        // Guards at the extremes keep the ramp saturating rather than wrapping,
        // even if the direction register were ever out of step.
        unique case (dir_q)
            DIR_UP:   cnt_d = (cnt_q == CNT_MAX)  ? cnt_q - CNT_ONE : cnt_q + CNT_ONE;
            DIR_DOWN: cnt_d = (cnt_q == CNT_ZERO) ? cnt_q + CNT_ONE : cnt_q - CNT_ONE;
            default:  cnt_d = CNT_ZERO;
        endcase

        if (cnt_d == CNT_MAX) begin
            dir_d = DIR_DOWN;
        end else if (cnt_d == CNT_ZERO) begin
            dir_d = DIR_UP;
        end

        pwm_d = ({1'b0, cnt_d} < DUTY_CMP);
    end

    // State register: async clear to the valley, counting up, output low.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            cnt_q <= CNT_ZERO;
            dir_q <= DIR_UP;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_bus.PWM_out   = pwm_q;
    assign pwm_bus.counter   = cnt_q;
    assign pwm_bus.direction = (dir_q == DIR_UP);
endmodule

// File: tb/tb_dual_slope_pwm.sv
// Self-checking bench for dual_slope_pwm. Five instances run side by side
// from a shared clock/reset (default, DUTY=0, DUTY=MAX, DUTY=2**N, and a
// 4-bit build). Expected values come from a closed-form model of the ramp
// as a function of clocks elapsed since reset release.
module tb_dual_slope_pwm;
    logic clk;
    logic rst;
    int   cyc;      // clocks since reset release
    int   checks;
    int   passes;

    dual_slope_pwm_if #(.RESOLUTION(10)) if_def   ();
    dual_slope_pwm_if #(.RESOLUTION(10)) if_d0    ();
    dual_slope_pwm_if #(.RESOLUTION(10)) if_dmax  ();
    dual_slope_pwm_if #(.RESOLUTION(10)) if_dfull ();
    dual_slope_pwm_if #(.RESOLUTION(4))  if_w4    ();

    dual_slope_pwm #(.RESOLUTION(10), .DUTY(256))  u_def   (.clk(clk), .rst(rst), .pwm_bus(if_def));
    dual_slope_pwm #(.RESOLUTION(10), .DUTY(0))    u_d0    (.clk(clk), .rst(rst), .pwm_bus(if_d0));
    dual_slope_pwm #(.RESOLUTION(10), .DUTY(1023)) u_dmax  (.clk(clk), .rst(rst), .pwm_bus(if_dmax));
    dual_slope_pwm #(.RESOLUTION(10), .DUTY(1024)) u_dfull (.clk(clk), .rst(rst), .pwm_bus(if_dfull));
    dual_slope_pwm #(.RESOLUTION(4),  .DUTY(4))    u_w4    (.clk(clk), .rst(rst), .pwm_bus(if_w4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Triangle wave: position within a 2*MAX period folded about the peak.
    function automatic int model_count(int n, int maxv);
        int c;
        c = n % (2 * maxv);
        return (c <= maxv) ? c : 2 * maxv - c;
    endfunction

    // Next step is upward everywhere on the rising half, including the valley.
    function automatic bit model_dir(int n, int maxv);
        return (n % (2 * maxv)) < maxv;
    endfunction

    function automatic bit model_pwm(int n, int maxv, int duty);
        if (n == 0) return 1'b0;
        return model_count(n, maxv) < duty;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #30 rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (if_def.counter !== 10'(model_count(cyc, 1023)))
            $display("FAIL pre_reset_count: got %0d want %0d", if_def.counter, model_count(cyc, 1023));
        else passes++;

        #(110 - $time);
        rst = 1'b1;
        #2;
        checks++; if (if_def.counter !== 10'd0)   $display("FAIL rst_def_count: got %0d want 0", if_def.counter);   else passes++;
        checks++; if (if_def.direction !== 1'b1)  $display("FAIL rst_def_dir: got %b want 1", if_def.direction);   else passes++;
        checks++; if (if_def.PWM_out !== 1'b0)    $display("FAIL rst_def_pwm: got %b want 0", if_def.PWM_out);     else passes++;
        checks++; if (if_dfull.PWM_out !== 1'b0)  $display("FAIL rst_dfull_pwm: got %b want 0", if_dfull.PWM_out); else passes++;
        checks++; if (if_dmax.PWM_out !== 1'b0)   $display("FAIL rst_dmax_pwm: got %b want 0", if_dmax.PWM_out);   else passes++;
        checks++; if (if_w4.counter !== 4'd0)     $display("FAIL rst_w4_count: got %0d want 0", if_w4.counter);    else passes++;
        checks++; if (if_w4.direction !== 1'b1)   $display("FAIL rst_w4_dir: got %b want 1", if_w4.direction);     else passes++;

        #8 rst = 1'b0;
        tick();
        checks++; if (if_def.counter !== 10'd1)   $display("FAIL first_def_count: got %0d want 1", if_def.counter); else passes++;
        checks++; if (if_def.PWM_out !== 1'b1)    $display("FAIL first_def_pwm: got %b want 1", if_def.PWM_out);    else passes++;
        checks++; if (if_d0.PWM_out !== 1'b0)     $display("FAIL first_d0_pwm: got %b want 0", if_d0.PWM_out);      else passes++;
        checks++; if (if_dfull.PWM_out !== 1'b1)  $display("FAIL first_dfull_pwm: got %b want 1", if_dfull.PWM_out); else passes++;
        checks++; if (if_w4.counter !== 4'd1)     $display("FAIL first_w4_count: got %0d want 1", if_w4.counter);   else passes++;
    endtask

    task automatic test_ramp();
        while (cyc < 2046) begin
            tick();
            checks++;
            if (if_def.counter !== 10'(model_count(cyc, 1023)) || if_def.direction !== model_dir(cyc, 1023)
                || if_def.PWM_out !== model_pwm(cyc, 1023, 256))
                $display("FAIL ramp_cyc%0d: got cnt=%0d dir=%b pwm=%b want cnt=%0d dir=%b pwm=%b", cyc,
                         if_def.counter, if_def.direction, if_def.PWM_out,
                         model_count(cyc, 1023), model_dir(cyc, 1023), model_pwm(cyc, 1023, 256));
            else passes++;
            if (cyc == 1023) begin
                checks++;
                if (if_def.counter !== 10'd1023 || if_def.direction !== 1'b0)
                    $display("FAIL ramp_peak: got cnt=%0d dir=%b want cnt=1023 dir=0", if_def.counter, if_def.direction);
                else passes++;
            end
            if (cyc == 1024) begin
                checks++;
                if (if_def.counter !== 10'd1022)
                    $display("FAIL ramp_after_peak: got %0d want 1022", if_def.counter);
                else passes++;
            end
        end
        checks++;
        if (if_def.counter !== 10'd0 || if_def.direction !== 1'b1)
            $display("FAIL ramp_valley: got cnt=%0d dir=%b want cnt=0 dir=1", if_def.counter, if_def.direction);
        else passes++;
    endtask

    task automatic test_duty();
        bit prev;
        bit have_rise;
        int run_len;
        int last_rise;
        prev      = if_def.PWM_out;
        have_rise = 1'b0;
        run_len   = 0;
        last_rise = 0;
        repeat (50000) begin
            tick();
            checks++;
            if (if_def.PWM_out !== model_pwm(cyc, 1023, 256))
                $display("FAIL duty_cyc%0d: got %b want %b", cyc, if_def.PWM_out, model_pwm(cyc, 1023, 256));
            else passes++;
            if (if_def.PWM_out !== prev) begin
                if (have_rise) begin
                    checks++;
                    if (prev && run_len != 511)
                        $display("FAIL duty_high_len: got %0d want 511", run_len);
                    else if (!prev && run_len != 1535)
                        $display("FAIL duty_low_len: got %0d want 1535", run_len);
                    else passes++;
                    if (!prev) begin
                        checks++;
                        if (cyc - last_rise != 2046)
                            $display("FAIL duty_period: got %0d want 2046", cyc - last_rise);
                        else passes++;
                    end
                end
                if (!prev) begin
                    have_rise = 1'b1;
                    last_rise = cyc;
                end
                run_len = 0;
            end
            run_len++;
            prev = if_def.PWM_out;
        end
    endtask

    task automatic test_boundaries();
        int lows;
        lows = 0;
        repeat (2 * 2046) begin
            tick();
            checks++;
            if (if_d0.PWM_out !== 1'b0)
                $display("FAIL d0_pwm_cyc%0d: got %b want 0", cyc, if_d0.PWM_out);
            else passes++;
            checks++;
            if (if_dfull.PWM_out !== 1'b1)
                $display("FAIL dfull_pwm_cyc%0d: got %b want 1", cyc, if_dfull.PWM_out);
            else passes++;
            checks++;
            if (if_dmax.PWM_out !== (model_count(cyc, 1023) != 1023))
                $display("FAIL dmax_pwm_cyc%0d: got %b want %b", cyc, if_dmax.PWM_out, model_count(cyc, 1023) != 1023);
            else passes++;
            if (if_dmax.PWM_out === 1'b0) begin
                lows++;
                checks++;
                if (if_dmax.counter !== 10'd1023)
                    $display("FAIL dmax_low_at: got cnt=%0d want 1023", if_dmax.counter);
                else passes++;
            end
        end
        checks++;
        if (lows != 2) $display("FAIL dmax_low_count: got %0d want 2", lows);
        else passes++;
    endtask

    // Assert reset a random few ns after an edge, confirm the clear happens
    // before the next edge, then confirm the ramp restarts upward from 0.
    task automatic pulse_reset_and_check(string tag);
        #($urandom_range(1, 6));
        rst = 1'b1;
        #1;
        checks++;
        if (if_def.counter !== 10'd0 || if_def.direction !== 1'b1 || if_def.PWM_out !== 1'b0
            || if_w4.counter !== 4'd0 || if_dfull.PWM_out !== 1'b0)
            $display("FAIL %s_clear: got cnt=%0d dir=%b pwm=%b w4=%0d full=%b want 0 1 0 0 0", tag,
                     if_def.counter, if_def.direction, if_def.PWM_out, if_w4.counter, if_dfull.PWM_out);
        else passes++;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        checks++;
        if (if_def.counter !== 10'd1 || if_def.direction !== 1'b1)
            $display("FAIL %s_restart: got cnt=%0d dir=%b want 1 1", tag, if_def.counter, if_def.direction);
        else passes++;
        repeat (40) begin
            tick();
            checks++;
            if (if_def.counter !== 10'(model_count(cyc, 1023)) || if_w4.counter !== 4'(model_count(cyc, 15))
                || if_w4.PWM_out !== model_pwm(cyc, 15, 4))
                $display("FAIL %s_cyc%0d: got def=%0d w4=%0d w4pwm=%b want %0d %0d %b", tag, cyc,
                         if_def.counter, if_w4.counter, if_w4.PWM_out,
                         model_count(cyc, 1023), model_count(cyc, 15), model_pwm(cyc, 15, 4));
            else passes++;
        end
    endtask

    task automatic test_mid_reset();
        int budget;
        budget = 0;
        while ((cyc % 2046) != 1446 && budget < 2100) begin
            tick();
            budget++;
        end
        checks++;
        if (if_def.counter !== 10'd600 || if_def.direction !== 1'b0)
            $display("FAIL mid_reach600: got cnt=%0d dir=%b want 600 0 (waited %0d)", if_def.counter, if_def.direction, budget);
        else passes++;
        pulse_reset_and_check("mid600");

        repeat ($urandom_range(50, 3000)) tick();
        pulse_reset_and_check("midrand");
    endtask

    task automatic test_width();
        bit prev;
        bit have_rise;
        int run_len;
        int last_rise;
        int peak;
        int periods;
        prev      = if_w4.PWM_out;
        have_rise = 1'b0;
        run_len   = 0;
        last_rise = 0;
        peak      = 0;
        periods   = 0;
        repeat (150) begin
            tick();
            if (int'(if_w4.counter) > peak) peak = int'(if_w4.counter);
            checks++;
            if (if_w4.counter !== 4'(model_count(cyc, 15)) || if_w4.direction !== model_dir(cyc, 15))
                $display("FAIL w4_cyc%0d: got cnt=%0d dir=%b want %0d %b", cyc, if_w4.counter, if_w4.direction,
                         model_count(cyc, 15), model_dir(cyc, 15));
            else passes++;
            if (if_w4.PWM_out !== prev) begin
                if (have_rise && prev) begin
                    checks++;
                    if (run_len != 7) $display("FAIL w4_high_len: got %0d want 7", run_len);
                    else passes++;
                end
                if (!prev) begin
                    if (have_rise) begin
                        periods++;
                        checks++;
                        if (cyc - last_rise != 30) $display("FAIL w4_period: got %0d want 30", cyc - last_rise);
                        else passes++;
                    end
                    have_rise = 1'b1;
                    last_rise = cyc;
                end
                run_len = 0;
            end
            run_len++;
            prev = if_w4.PWM_out;
        end
        checks++;
        if (peak != 15) $display("FAIL w4_peak: got %0d want 15", peak);
        else passes++;
        checks++;
        if (periods < 3) $display("FAIL w4_periods_seen: got %0d want >=3", periods);
        else passes++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        test_reset();
        test_ramp();
        test_duty();
        test_boundaries();
        test_mid_reset();
        test_width();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
